// File: rtl/calc_run_ctrl.sv
// calc_run_ctrl: sequences one calculator run. It hands the shared data memory to the CPU,
// enforces a run-cycle budget, then reads the result word back for the display logic.
module calc_run_ctrl #(
  parameter logic [31:0] RESULT_ADDR = 32'd460,
  parameter int unsigned MAX_CYCLES  = 200
) (
  input  logic        hz100,
  input  logic        reset,
  input  logic        start,
  input  logic        clear,
  input  logic        fe_wr_en,
  input  logic [31:0] fe_addr,
  input  logic [31:0] fe_wdata,
  input  logic        cpu_mem_en,
  input  logic        cpu_wr,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_halt,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        cpu_enable,
  output logic [31:0] result,
  output logic        result_valid,
  output logic        busy,
  output logic        timeout,
  output logic        fe_reject
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    FETCH   = 3'd2,
    WAIT_RD = 3'd3,
    DONE    = 3'd4,
    ERR     = 3'd5
  } state_t;

  localparam logic [15:0] LAST_CYCLE = 16'(MAX_CYCLES - 1);

  state_t      state;
  state_t      state_next;
  logic [15:0] counter;
  logic [15:0] counter_inc;
  logic        idle_like;
  logic        run_start;
  logic        run_stop;

  assign idle_like   = (state == IDLE) || (state == DONE) || (state == ERR);
  assign run_start   = idle_like && start && !clear;
  assign run_stop    = (state == RUN) && (state_next != RUN);
  assign counter_inc = (counter == 16'hFFFF) ? counter : counter + 16'd1;

  // State register.
  always_ff @(posedge hz100 or posedge reset) begin
    // NOTE: clocked blocks use non-blocking assignments only, so every register
    // samples pre-edge values regardless of the order blocks are evaluated in.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic; clear overrides everything, including start.
  always_comb begin
    // NOTE: default assignment first, so no path through the case can leave
    // state_next unassigned and infer a latch.
    state_next = state;
    if (clear) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE, DONE, ERR: if (start) state_next = RUN;
        RUN: begin
          // halt takes priority over the budget expiring in the same cycle
          if (cpu_halt)                   state_next = FETCH;
          else if (counter == LAST_CYCLE) state_next = ERR;
        end
        FETCH:   state_next = WAIT_RD;
        WAIT_RD: state_next = DONE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Output decode: memory-port ownership and busy follow the state alone.
  always_comb begin
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    busy      = 1'b0;
    case (state)
      RUN: begin
        mem_en    = cpu_mem_en;
        mem_wr    = cpu_wr;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        busy      = 1'b1;
      end
      FETCH: begin
        mem_en   = 1'b1;
        mem_addr = RESULT_ADDR;
        busy     = 1'b1;
      end
      WAIT_RD: busy = 1'b1;
      default: begin
        mem_en    = fe_wr_en;
        mem_wr    = fe_wr_en;
        mem_addr  = fe_addr;
        mem_wdata = fe_wdata;
      end
    endcase
  end

  // Run bookkeeping and status registers.
  always_ff @(posedge hz100 or posedge reset) begin
    if (reset) begin
      counter      <= '0;
      cpu_enable   <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      timeout      <= 1'b0;
      fe_reject    <= 1'b0;
    end else begin
      // a front-end write arriving while busy is dropped by the port mux; flag it
      fe_reject <= fe_wr_en && busy;
      if (clear) begin
        counter      <= '0;
        cpu_enable   <= 1'b0;
        result       <= '0;
        result_valid <= 1'b0;
        timeout      <= 1'b0;
      end else begin
        counter <= ((state == RUN) && (state_next == RUN)) ? counter_inc : '0;
        if (run_start) begin
          cpu_enable   <= 1'b1;
          result_valid <= 1'b0;
          timeout      <= 1'b0;
        end
        if (run_stop) begin
          cpu_enable <= 1'b0;
          if (state_next == ERR) timeout <= 1'b1;
        end
        if (state == WAIT_RD) begin
          result       <= mem_rdata;
          result_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_calc_run_ctrl.sv
// Bench for calc_run_ctrl: directed scenarios plus random traffic, all compared every cycle
// against a run-level behavioural model driving its own copy of the data memory.
module tb_calc_run_ctrl;

  localparam logic [31:0] RESULT_ADDR = 32'd460;
  localparam int          MAX_CYCLES  = 200;

  logic        hz100 = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0, clear = 1'b0;
  logic        fe_wr_en = 1'b0;
  logic [31:0] fe_addr = '0, fe_wdata = '0;
  logic        cpu_mem_en = 1'b0, cpu_wr = 1'b0, cpu_halt = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic        mem_en, mem_wr;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        cpu_enable, result_valid, busy, timeout, fe_reject;
  logic [31:0] result;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  calc_run_ctrl #(.RESULT_ADDR(RESULT_ADDR), .MAX_CYCLES(MAX_CYCLES)) dut (
    .hz100(hz100), .reset(reset), .start(start), .clear(clear),
    .fe_wr_en(fe_wr_en), .fe_addr(fe_addr), .fe_wdata(fe_wdata),
    .cpu_mem_en(cpu_mem_en), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_halt(cpu_halt),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .cpu_enable(cpu_enable), .result(result), .result_valid(result_valid),
    .busy(busy), .timeout(timeout), .fe_reject(fe_reject)
  );

  always #5 hz100 = ~hz100;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Data memory seen by the DUT: writes land on the edge, read data returns next cycle.
  logic [31:0] env_mem [0:511];
  always @(posedge hz100) begin
    if (mem_en) begin
      if (mem_wr) env_mem[mem_addr[8:0]] <= mem_wdata;
      else        mem_rdata <= env_mem[mem_addr[8:0]];
    end
  end

  // Behavioural model: a run is "running" for a counted number of cycles, then the
  // result fetch takes two further cycles (read issued, data returned).
  bit          m_running   = 1'b0;
  int          m_elapsed   = 0;
  int          m_fetch     = 0;
  bit          m_cpu_en    = 1'b0;
  bit          m_valid     = 1'b0;
  bit          m_timeout   = 1'b0;
  bit          m_reject    = 1'b0;
  logic [31:0] m_result    = '0;
  logic [31:0] m_rd        = '0;
  logic [31:0] m_mem [0:511];

  function automatic bit m_busy();
    return m_running || (m_fetch != 0);
  endfunction

  function automatic void exp_port(output logic en, output logic wr,
                                   output logic [31:0] addr, output logic [31:0] wdata);
    en = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    if (m_running) begin
      en = cpu_mem_en; wr = cpu_wr; addr = cpu_addr; wdata = cpu_wdata;
    end else if (m_fetch == 1) begin
      en = 1'b1; addr = RESULT_ADDR;
    end else if (m_fetch == 0) begin
      en = fe_wr_en; wr = fe_wr_en; addr = fe_addr; wdata = fe_wdata;
    end
  endfunction

  always @(posedge hz100 or posedge reset) begin : model
    logic        e, w;
    logic [31:0] a, d;
    bit          was_busy;
    if (reset) begin
      m_running = 1'b0; m_elapsed = 0; m_fetch = 0;
      m_cpu_en = 1'b0; m_valid = 1'b0; m_timeout = 1'b0; m_reject = 1'b0;
      m_result = '0;
    end else begin
      exp_port(e, w, a, d);
      if (e && w)  m_mem[a[8:0]] = d;
      if (e && !w) m_rd = m_mem[a[8:0]];
      was_busy = m_busy();
      m_reject = fe_wr_en && was_busy;
      if (clear) begin
        m_running = 1'b0; m_elapsed = 0; m_fetch = 0;
        m_cpu_en = 1'b0; m_valid = 1'b0; m_timeout = 1'b0; m_result = '0;
      end else if (m_running) begin
        if (cpu_halt) begin
          m_running = 1'b0; m_fetch = 1; m_cpu_en = 1'b0;
        end else if (m_elapsed == MAX_CYCLES - 1) begin
          m_running = 1'b0; m_cpu_en = 1'b0; m_timeout = 1'b1;
        end else begin
          m_elapsed++;
        end
      end else if (m_fetch == 1) begin
        m_fetch = 2;
      end else if (m_fetch == 2) begin
        m_fetch = 0; m_result = m_rd; m_valid = 1'b1;
      end else if (start) begin
        m_running = 1'b1; m_elapsed = 0; m_cpu_en = 1'b1;
        m_valid = 1'b0; m_timeout = 1'b0;
      end
    end
  end

  always @(negedge hz100) begin : compare
    logic        e, w;
    logic [31:0] a, d;
    if (chk_en && !reset) begin
      exp_port(e, w, a, d);
      check("mem_en", 32'(mem_en), 32'(e));
      if (e) begin
        check("mem_wr", 32'(mem_wr), 32'(w));
        check("mem_addr", mem_addr, a);
        check("mem_wdata", mem_wdata, d);
      end
      check("busy", 32'(busy), 32'(m_busy()));
      check("cpu_enable", 32'(cpu_enable), 32'(m_cpu_en));
      check("result", result, m_result);
      check("result_valid", 32'(result_valid), 32'(m_valid));
      check("timeout", 32'(timeout), 32'(m_timeout));
      check("fe_reject", 32'(fe_reject), 32'(m_reject));
    end
  end

  task automatic cyc();
    @(posedge hz100);
    #2;
  endtask

  task automatic fe_write(input logic [31:0] addr, input logic [31:0] data);
    fe_wr_en = 1'b1; fe_addr = addr; fe_wdata = data;
    cyc();
    fe_wr_en = 1'b0;
  endtask

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 4))
      0:       return 32'd220;
      1:       return 32'd260;
      2:       return 32'd300;
      3:       return RESULT_ADDR;
      default: return $urandom;
    endcase
  endfunction

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    int edges;
    int run;
    for (int i = 0; i < 512; i++) begin
      env_mem[i] = '0;
      m_mem[i]   = '0;
    end

    // Reset state
    cyc();
    check("rst_result", result, 32'd0);
    check("rst_valid", 32'(result_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cpu_en", 32'(cpu_enable), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_fe_reject", 32'(fe_reject), 32'd0);
    reset = 1'b0;
    chk_en = 1'b1;
    cyc();

    // Operand load, start with a same-cycle write, halt after 10 RUN cycles
    fe_write(32'd220, 32'd7);
    fe_write(32'd260, 32'd5);
    fe_wr_en = 1'b1; fe_addr = 32'd300; fe_wdata = 32'd8; start = 1'b1;
    cyc();
    fe_wr_en = 1'b0; start = 1'b0; edges = 1;
    check("wr_with_start", env_mem[300], 32'd8);
    check("busy_after_start", 32'(busy), 32'd1);
    run = 1;
    while (!result_valid && edges < 40) begin
      cpu_mem_en = (run == 1); cpu_wr = 1'b1; cpu_addr = RESULT_ADDR; cpu_wdata = 32'd35;
      cpu_halt = (run == 10);
      cyc();
      edges++; run++;
      cpu_halt = 1'b0; cpu_mem_en = 1'b0;
    end
    check("latency_edges", 32'(edges), 32'd13);
    check("result_35", result, 32'd35);
    check("done_busy", 32'(busy), 32'd0);

    // Rejected front-end write during RUN, then run out the budget
    start = 1'b1; cyc(); start = 1'b0; edges = 1;
    cyc(); edges++;
    fe_wr_en = 1'b1; fe_addr = 32'd220; fe_wdata = 32'd99;
    #1 check("mem_en_cpu_only", 32'(mem_en), 32'd0);
    cyc(); edges++;
    fe_wr_en = 1'b0;
    check("fe_reject_pulse", 32'(fe_reject), 32'd1);
    cyc(); edges++;
    check("fe_reject_drop", 32'(fe_reject), 32'd0);
    check("mem220_kept", env_mem[220], 32'd7);
    while (!timeout && edges < 400) begin
      cyc(); edges++;
    end
    check("timeout_edges", 32'(edges), 32'd201);
    check("timeout_set", 32'(timeout), 32'd1);
    check("timeout_cpu_en", 32'(cpu_enable), 32'd0);
    check("timeout_valid", 32'(result_valid), 32'd0);
    check("timeout_result_kept", result, 32'd35);

    // Halt exactly on the last budget cycle
    start = 1'b1; cyc(); start = 1'b0; run = 1;
    while (run < MAX_CYCLES) begin
      cyc(); run++;
    end
    cpu_halt = 1'b1; cyc(); cpu_halt = 1'b0;
    check("edge_halt_timeout", 32'(timeout), 32'd0);
    check("edge_halt_busy", 32'(busy), 32'd1);
    cyc(); cyc();
    check("edge_halt_valid", 32'(result_valid), 32'd1);
    check("edge_halt_result", result, 32'd35);

    // clear beats start in DONE
    clear = 1'b1; start = 1'b1; cyc(); clear = 1'b0; start = 1'b0;
    check("clr_result", result, 32'd0);
    check("clr_valid", 32'(result_valid), 32'd0);
    check("clr_cpu_en", 32'(cpu_enable), 32'd0);
    check("clr_busy", 32'(busy), 32'd0);

    // Reload a result, then reset asynchronously while the read is outstanding
    start = 1'b1; cyc(); start = 1'b0;
    cpu_halt = 1'b1; cyc(); cpu_halt = 1'b0;
    cyc(); cyc();
    check("reload_result", result, 32'd35);
    start = 1'b1; cyc(); start = 1'b0;
    cpu_halt = 1'b1; cyc(); cpu_halt = 1'b0;
    cyc();
    check("in_wait_busy", 32'(busy), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_result", result, 32'd0);
    check("arst_valid", 32'(result_valid), 32'd0);
    check("arst_cpu_en", 32'(cpu_enable), 32'd0);
    check("arst_mem_en", 32'(mem_en), 32'd0);
    cyc();
    reset = 1'b0;
    cyc();
    check("arst_no_capture", result, 32'd0);
    check("arst_valid_after", 32'(result_valid), 32'd0);

    // Random traffic
    repeat (3000) begin
      start      = ($urandom_range(0, 19) == 0);
      clear      = ($urandom_range(0, 59) == 0);
      fe_wr_en   = ($urandom_range(0, 3) == 0);
      fe_addr    = pick_addr();
      fe_wdata   = $urandom;
      cpu_mem_en = ($urandom_range(0, 2) == 0);
      cpu_wr     = 1'($urandom_range(0, 1));
      cpu_addr   = pick_addr();
      cpu_wdata  = $urandom;
      cpu_halt   = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 499) == 0) begin
        #1 reset = 1'b1;
        #1 reset = 1'b0;
      end
      cyc();
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
